// File: rtl/bf_pkg.sv
// Shared definitions for the BF program-counter unit: opcode bytes,
// the PC unit state encoding and the error codes reported on err_code.
package bf_pkg;

    localparam logic [7:0] OP_LOOP_OPEN  = 8'h5B;   // '['
    localparam logic [7:0] OP_LOOP_CLOSE = 8'h5D;   // ']'
    localparam logic [7:0] OP_END        = 8'h00;   // end of program

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        SCAN = 2'd1,
        HALT = 2'd2,
        ERR  = 2'd3
    } pc_state_t;

    typedef enum logic [1:0] {
        ERR_NONE      = 2'b00,
        ERR_OVF       = 2'b01,
        ERR_UNF       = 2'b10,
        ERR_UNMATCHED = 2'b11
    } err_code_t;

endpackage

// File: rtl/bf_loop_stack.sv
// Loop-return LIFO holding the addresses of open '[' instructions.
// The top entry is read combinationally so a taken ']' can jump back
// in the same cycle. Reset (synchronous, active-high) empties the stack;
// the storage array itself is not reset.
module bf_loop_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         top,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] top_idx;

    assign wr_idx  = count_q[IDX_W-1:0];
    assign top_idx = count_q[IDX_W-1:0] - 1'b1;
    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign top     = mem[top_idx];
    assign count   = count_q;

    // Occupancy update; a push when full or a pop when empty is ignored.
    always_comb begin
        count_d = count_q;
        if (push && !full) begin
            count_d = count_q + 1'b1;
        end else if (pop && !empty) begin
            count_d = count_q - 1'b1;
        end
    end

    // Occupancy register.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Entry storage, written at the current occupancy index on push.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_idx] <= din;
        end
    end

endmodule

// File: rtl/bf_pc_unit.sv
// Program-counter unit for the BF machine: PC, hardware loop stack for
// '[' / ']', single-cycle backward jumps and a byte-per-cycle forward
// scan to skip loops entered with a zero cell.
// Optional build macro BF_PC_REWIND_EN adds a 'rewind' input that
// restarts the unit from any state (reset still takes priority).
module bf_pc_unit
    import bf_pkg::*;
#(
    parameter int PC_W        = 8,
    parameter int STACK_DEPTH = 16,
    parameter int NEST_W      = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           step,
    input  logic [7:0]                     instr,
    input  logic                           data_zero,
`ifdef BF_PC_REWIND_EN
    input  logic                           rewind,
`endif
    output logic [PC_W-1:0]                pc,
    output logic                           busy,
    output logic                           halted,
    output logic                           error,
    output logic [1:0]                     err_code,
    output logic [$clog2(STACK_DEPTH):0]   depth
);

    localparam logic [NEST_W-1:0] NEST_MAX = {NEST_W{1'b1}};

    pc_state_t          state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [NEST_W-1:0]  nest_q, nest_d;
    err_code_t          err_q, err_d;
    logic               busy_q, busy_d;
    logic               halted_q, halted_d;
    logic               error_q, error_d;

    logic               stk_push;
    logic               stk_pop;
    logic               stk_reset;
    logic [PC_W-1:0]    stk_top;
    logic               stk_full;
    logic               stk_empty;
    logic               restart;
    logic [PC_W-1:0]    pc_inc;
    logic [PC_W-1:0]    top_inc;

`ifdef BF_PC_REWIND_EN
    assign restart = rewind;
`else
    assign restart = 1'b0;
`endif

    assign stk_reset = reset | restart;
    assign pc_inc    = pc_q + PC_W'(1);
    assign top_inc   = stk_top + PC_W'(1);

    bf_loop_stack #(
        .WIDTH (PC_W),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk   (clk),
        .reset (stk_reset),
        .push  (stk_push),
        .pop   (stk_pop),
        .din   (pc_q),
        .top   (stk_top),
        .full  (stk_full),
        .empty (stk_empty),
        .count (depth)
    );

    // State, PC, nesting and error registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= RUN;
            pc_q     <= '0;
            nest_q   <= '0;
            err_q    <= ERR_NONE;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            nest_q   <= nest_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            halted_q <= halted_d;
            error_q  <= error_d;
        end
    end

    // Next-state logic: instruction execution in RUN, bracket scan in SCAN.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        nest_d   = nest_q;
        err_d    = err_q;
        stk_push = 1'b0;
        stk_pop  = 1'b0;
        if (restart) begin
            state_d = RUN;
            pc_d    = '0;
            nest_d  = '0;
            err_d   = ERR_NONE;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (step) begin
                        case (instr)
                            OP_LOOP_OPEN: begin
                                if (data_zero) begin
                                    nest_d  = NEST_W'(1);
                                    pc_d    = pc_inc;
                                    state_d = SCAN;
                                end else if (stk_full) begin
                                    state_d = ERR;
                                    err_d   = ERR_OVF;
                                end else begin
                                    stk_push = 1'b1;
                                    pc_d     = pc_inc;
                                end
                            end
                            OP_LOOP_CLOSE: begin
                                if (stk_empty) begin
                                    state_d = ERR;
                                    err_d   = ERR_UNF;
                                end else if (!data_zero) begin
                                    pc_d = top_inc;
                                end else begin
                                    stk_pop = 1'b1;
                                    pc_d    = pc_inc;
                                end
                            end
                            OP_END: begin
                                state_d = HALT;
                            end
                            default: begin
                                pc_d = pc_inc;
                            end
                        endcase
                    end
                end
                SCAN: begin
                    case (instr)
                        OP_LOOP_OPEN: begin
                            if (nest_q == NEST_MAX) begin
                                state_d = ERR;
                                err_d   = ERR_UNMATCHED;
                            end else begin
                                nest_d = nest_q + 1'b1;
                                pc_d   = pc_inc;
                            end
                        end
                        OP_LOOP_CLOSE: begin
                            nest_d = nest_q - 1'b1;
                            pc_d   = pc_inc;
                            if (nest_q == NEST_W'(1)) begin
                                state_d = RUN;
                            end
                        end
                        OP_END: begin
                            state_d = ERR;
                            err_d   = ERR_UNMATCHED;
                        end
                        default: begin
                            pc_d = pc_inc;
                        end
                    endcase
                end
                HALT: begin
                end
                ERR: begin
                end
            endcase
        end
    end

    // Status flags decoded from the next state so they are registered with it.
    always_comb begin
        busy_d   = (state_d == SCAN);
        halted_d = (state_d == HALT);
        error_d  = (state_d == ERR);
    end

    assign pc       = pc_q;
    assign busy     = busy_q;
    assign halted   = halted_q;
    assign error    = error_q;
    assign err_code = err_q;

endmodule

// File: tb/tb_bf_pc_unit.sv
// Bench for bf_pc_unit: directed scenarios plus randomized programs
// checked against a queue-based behavioural model of the PC unit.
module tb_bf_pc_unit;

    localparam int PC_W = 8;
    localparam int SD   = 2;
    localparam int NW   = 2;
    localparam int DW   = $clog2(SD) + 1;
    localparam int NMAX = (1 << NW) - 1;
    localparam int MEM  = 1 << PC_W;

    localparam int M_RUN  = 0;
    localparam int M_SCAN = 1;
    localparam int M_HALT = 2;
    localparam int M_ERR  = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic            step;
    logic            data_zero;
    logic [7:0]      instr;
    logic [PC_W-1:0] pc;
    logic            busy;
    logic            halted;
    logic            error;
    logic [1:0]      err_code;
    logic [DW-1:0]   depth;
`ifdef BF_PC_REWIND_EN
    logic            rewind;
`endif

    logic [7:0] prog [MEM];
    assign instr = prog[pc];

    int checks   = 0;
    int failures = 0;

    // model state
    int m_pc;
    int m_stk[$];
    int m_nest;
    int m_st;
    int m_err;

    always #5 clk = ~clk;

    bf_pc_unit #(
        .PC_W        (PC_W),
        .STACK_DEPTH (SD),
        .NEST_W      (NW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .step      (step),
        .instr     (instr),
        .data_zero (data_zero),
`ifdef BF_PC_REWIND_EN
        .rewind    (rewind),
`endif
        .pc        (pc),
        .busy      (busy),
        .halted    (halted),
        .error     (error),
        .err_code  (err_code),
        .depth     (depth)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step = 1'b0;
        data_zero = 1'b0;
`ifdef BF_PC_REWIND_EN
        rewind = 1'b0;
`endif
        cyc();
        reset = 1'b0;
    endtask

    task automatic load(input string s);
        for (int i = 0; i < MEM; i++) prog[i] = 8'h00;
        for (int i = 0; i < s.len(); i++) prog[i] = s[i];
    endtask

    task automatic model_reset();
        m_pc = 0;
        m_stk.delete();
        m_nest = 0;
        m_st = M_RUN;
        m_err = 0;
    endtask

    task automatic model_step(input bit stp, input bit dz);
        int b;
        b = int'(prog[m_pc]);
        if (m_st == M_RUN && stp) begin
            if (b == 'h5B) begin
                if (dz) begin
                    m_nest = 1; m_pc = (m_pc + 1) % MEM; m_st = M_SCAN;
                end else if (m_stk.size() == SD) begin
                    m_st = M_ERR; m_err = 1;
                end else begin
                    m_stk.push_back(m_pc); m_pc = (m_pc + 1) % MEM;
                end
            end else if (b == 'h5D) begin
                if (m_stk.size() == 0) begin
                    m_st = M_ERR; m_err = 2;
                end else if (!dz) begin
                    m_pc = (m_stk[$] + 1) % MEM;
                end else begin
                    void'(m_stk.pop_back()); m_pc = (m_pc + 1) % MEM;
                end
            end else if (b == 0) begin
                m_st = M_HALT;
            end else begin
                m_pc = (m_pc + 1) % MEM;
            end
        end else if (m_st == M_SCAN) begin
            if (b == 'h5B) begin
                if (m_nest == NMAX) begin
                    m_st = M_ERR; m_err = 3;
                end else begin
                    m_nest++; m_pc = (m_pc + 1) % MEM;
                end
            end else if (b == 'h5D) begin
                m_nest--; m_pc = (m_pc + 1) % MEM;
                if (m_nest == 0) m_st = M_RUN;
            end else if (b == 0) begin
                m_st = M_ERR; m_err = 3;
            end else begin
                m_pc = (m_pc + 1) % MEM;
            end
        end
    endtask

    task automatic test_reset();
        load("+[");
        do_reset();
        step = 1'b1; data_zero = 1'b0;
        cyc(); cyc();
        checks++; if (depth !== DW'(1)) begin failures++; $display("FAIL reset_pre_depth: got %0d expected 1", depth); end
        do_reset();
        checks++; if (pc !== '0) begin failures++; $display("FAIL reset_pc: got %0d expected 0", pc); end
        checks++; if (depth !== '0) begin failures++; $display("FAIL reset_depth: got %0d expected 0", depth); end
        checks++; if ({busy, halted, error, err_code} !== 5'b0) begin failures++; $display("FAIL reset_flags: got busy=%0b halted=%0b error=%0b err_code=%0d expected all 0", busy, halted, error, err_code); end
    endtask

    task automatic test_straight();
        load("+>+");
        do_reset();
        step = 1'b1; data_zero = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            cyc();
            checks++; if (pc !== PC_W'(i)) begin failures++; $display("FAIL straight_pc: got %0d expected %0d", pc, i); end
        end
        cyc();
        checks++; if (halted !== 1'b1 || pc !== PC_W'(3)) begin failures++; $display("FAIL straight_halt: got halted=%0b pc=%0d expected halted=1 pc=3", halted, pc); end
        cyc();
        checks++; if (halted !== 1'b1 || pc !== PC_W'(3)) begin failures++; $display("FAIL straight_hold: got halted=%0b pc=%0d expected halted=1 pc=3", halted, pc); end
        step = 1'b0;
    endtask

    task automatic test_loop();
        load("[-]");
        do_reset();
        step = 1'b1; data_zero = 1'b0;
        cyc();
        checks++; if (pc !== PC_W'(1) || depth !== DW'(1)) begin failures++; $display("FAIL loop_push: got pc=%0d depth=%0d expected pc=1 depth=1", pc, depth); end
        cyc();
        cyc();
        checks++; if (pc !== PC_W'(1) || depth !== DW'(1)) begin failures++; $display("FAIL loop_back: got pc=%0d depth=%0d expected pc=1 depth=1", pc, depth); end
        cyc();
        data_zero = 1'b1;
        cyc();
        checks++; if (pc !== PC_W'(3) || depth !== '0) begin failures++; $display("FAIL loop_exit: got pc=%0d depth=%0d expected pc=3 depth=0", pc, depth); end
        step = 1'b0;
    endtask

    task automatic test_skip_nested();
        int n;
        load("[[+]-]+");
        do_reset();
        step = 1'b1; data_zero = 1'b1;
        cyc();
        step = 1'b0;
        n = 1;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL skip_busy: got %0b expected 1", busy); end
        while (busy === 1'b1 && n < 20) begin
            cyc();
            n++;
        end
        checks++; if (n != 6) begin failures++; $display("FAIL skip_cycles: got %0d expected 6", n); end
        checks++; if (pc !== PC_W'(6) || depth !== '0 || error !== 1'b0) begin failures++; $display("FAIL skip_end: got pc=%0d depth=%0d error=%0b expected pc=6 depth=0 error=0", pc, depth, error); end
    endtask

    task automatic test_overflow();
        load("[[[");
        do_reset();
        step = 1'b1; data_zero = 1'b0;
        cyc(); cyc();
        checks++; if (depth !== DW'(2) || error !== 1'b0) begin failures++; $display("FAIL ovf_full: got depth=%0d error=%0b expected depth=2 error=0", depth, error); end
        cyc();
        checks++; if (error !== 1'b1 || err_code !== 2'b01 || pc !== PC_W'(2)) begin failures++; $display("FAIL ovf_err: got error=%0b err_code=%0d pc=%0d expected 1/1/2", error, err_code, pc); end
        step = 1'b0;
    endtask

    task automatic test_errors();
        load("]");
        do_reset();
        step = 1'b1; data_zero = 1'b1;
        cyc();
        checks++; if (error !== 1'b1 || err_code !== 2'b10 || pc !== '0) begin failures++; $display("FAIL underflow: got error=%0b err_code=%0d pc=%0d expected 1/2/0", error, err_code, pc); end
        load("[+");
        do_reset();
        step = 1'b1; data_zero = 1'b1;
        cyc(); cyc(); cyc();
        checks++; if (error !== 1'b1 || err_code !== 2'b11 || pc !== PC_W'(2) || busy !== 1'b0) begin failures++; $display("FAIL unmatched: got error=%0b err_code=%0d pc=%0d busy=%0b expected 1/3/2/0", error, err_code, pc, busy); end
        load("[[[[");
        do_reset();
        step = 1'b1; data_zero = 1'b1;
        cyc(); cyc(); cyc(); cyc();
        checks++; if (error !== 1'b1 || err_code !== 2'b11 || pc !== PC_W'(3)) begin failures++; $display("FAIL nest_sat: got error=%0b err_code=%0d pc=%0d expected 1/3/3", error, err_code, pc); end
        step = 1'b0;
    endtask

    task automatic test_wrap();
        for (int i = 0; i < MEM; i++) prog[i] = 8'h2B;
        do_reset();
        step = 1'b1; data_zero = 1'b0;
        for (int i = 0; i < MEM; i++) cyc();
        checks++; if (pc !== '0 || error !== 1'b0 || halted !== 1'b0) begin failures++; $display("FAIL wrap: got pc=%0d error=%0b halted=%0b expected 0/0/0", pc, error, halted); end
        step = 1'b0;
    endtask

    task automatic test_reset_mid_scan(input bit use_rewind);
        load("[[[+]]]");
        do_reset();
        step = 1'b1; data_zero = 1'b0;
        cyc();
        data_zero = 1'b1;
        cyc();
        step = 1'b0;
        cyc(); cyc();
        checks++; if (busy !== 1'b1 || pc !== PC_W'(4) || depth !== DW'(1)) begin failures++; $display("FAIL midscan_pre: got busy=%0b pc=%0d depth=%0d expected 1/4/1", busy, pc, depth); end
        step = 1'b1;
        if (use_rewind) begin
`ifdef BF_PC_REWIND_EN
            rewind = 1'b1;
            cyc();
            rewind = 1'b0;
`endif
        end else begin
            reset = 1'b1;
            cyc();
            reset = 1'b0;
        end
        step = 1'b0;
        checks++; if (pc !== '0 || busy !== 1'b0 || depth !== '0 || error !== 1'b0) begin failures++; $display("FAIL midscan_%s: got pc=%0d busy=%0b depth=%0d error=%0b expected all 0", use_rewind ? "rewind" : "reset", pc, busy, depth, error); end
    endtask

    task automatic test_random();
        int r;
        bit s;
        bit dz;
        bit exp_busy;
        bit exp_halt;
        bit exp_err;
        for (int p = 0; p < 40; p++) begin
            for (int i = 0; i < MEM; i++) begin
                r = $urandom_range(0, 99);
                if (r < 22) prog[i] = 8'h5B;
                else if (r < 44) prog[i] = 8'h5D;
                else if (r < 46) prog[i] = 8'h00;
                else if (r < 65) prog[i] = 8'h2B;
                else if (r < 80) prog[i] = 8'h2D;
                else if (r < 90) prog[i] = 8'h3E;
                else prog[i] = 8'h3C;
            end
            do_reset();
            model_reset();
            for (int c = 0; c < 300; c++) begin
                s = ($urandom_range(0, 3) != 0);
                dz = 1'($urandom_range(0, 1));
                step = s;
                data_zero = dz;
                cyc();
                model_step(s, dz);
                exp_busy = (m_st == M_SCAN);
                exp_halt = (m_st == M_HALT);
                exp_err = (m_st == M_ERR);
                checks++;
                if (pc !== PC_W'(m_pc) || busy !== exp_busy || halted !== exp_halt || error !== exp_err ||
                    err_code !== 2'(m_err) || depth !== DW'(m_stk.size())) begin
                    failures++;
                    $display("FAIL random prog=%0d cyc=%0d: got pc=%0d busy=%0b halted=%0b error=%0b err_code=%0d depth=%0d, expected pc=%0d busy=%0b halted=%0b error=%0b err_code=%0d depth=%0d",
                             p, c, pc, busy, halted, error, err_code, depth,
                             m_pc, exp_busy, exp_halt, exp_err, m_err, m_stk.size());
                    break;
                end
                if (m_st == M_HALT || m_st == M_ERR) break;
            end
        end
        step = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        step = 1'b0;
        data_zero = 1'b0;
`ifdef BF_PC_REWIND_EN
        rewind = 1'b0;
`endif
        load("");
        cyc();
        test_reset();
        test_straight();
        test_loop();
        test_skip_nested();
        test_overflow();
        test_errors();
        test_wrap();
        test_reset_mid_scan(1'b0);
`ifdef BF_PC_REWIND_EN
        test_reset_mid_scan(1'b1);
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
